// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its round-robin picker.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_BE_WIDTH   = 4;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/data_memory_arbiter_picker.sv
// round_robin_picker: combinational request vector + pointer to one-hot grant
// and encoded index. The first requester at or after the pointer wins, with
// wrap-around. Kept free of memory specifics so the instruction-memory arbiter
// can reuse it.
module round_robin_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IDX_W-1:0]     pointer,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_index,
  output logic                 grant_valid
);

  // Scan from the pointer upward with wrap; the first hit takes the grant.
  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand = (int'(pointer) + off) % NUM_PORTS;
      if (!grant_valid && request[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the single-ported DMEM between NUM_PORTS
// load/store requesters. One grant per cycle, round-robin fair; the granted
// payload drives the memory in the same cycle and the response (read data or
// write acknowledge) returns to the granted port one cycle later.
// Optional read-modify-write lock, enabled with the DMEM_ARB_LOCK_EN macro.
//
// Lock FSM (only with DMEM_ARB_LOCK_EN):
//   state     | meaning
//   LOCK_IDLE | plain round-robin arbitration
//   LOCK_HELD | only lock_owner may be granted, priority pointer frozen
module data_memory_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int LOCK_MAX_CYCLES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  port_request_valid,
  input  logic [NUM_PORTS*DMEM_ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*DMEM_DATA_WIDTH-1:0]  port_write_data,
  input  logic [NUM_PORTS*DMEM_BE_WIDTH-1:0]    port_byte_enable,
  input  logic [NUM_PORTS-1:0]                  port_write_enable,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0]                  port_lock,
`endif
  output logic [NUM_PORTS-1:0]                  port_grant,
  output logic [NUM_PORTS-1:0]                  port_response_valid,
  output logic [DMEM_DATA_WIDTH-1:0]            port_read_data,
  output logic                                  data_memory_enable,
  output logic [DMEM_ADDR_WIDTH-1:0]            data_memory_address,
  output logic [DMEM_DATA_WIDTH-1:0]            data_memory_write_data,
  output logic [DMEM_BE_WIDTH-1:0]              data_memory_byte_enable,
  output logic                                  data_memory_write_enable,
  input  logic [DMEM_DATA_WIDTH-1:0]            data_memory_read_data
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || LOCK_MAX_CYCLES < 1) begin : g_param_check
    $error("data_memory_arbiter: NUM_PORTS must be 2..8 and LOCK_MAX_CYCLES >= 1");
  end

  logic [IDX_W-1:0]     priority_pointer_q, priority_pointer_d;
  logic [NUM_PORTS-1:0] response_port_q;
  logic                 response_is_store_q;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_index;
  logic                 grant_valid;
  logic                 pointer_frozen;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX_CYCLES + 1);

  lock_state_t          lock_state_q;
  logic [IDX_W-1:0]     lock_owner_q;
  logic [CNT_W-1:0]     lock_counter_q, lock_counter_d;
  logic [NUM_PORTS-1:0] owner_mask;

  assign owner_mask     = NUM_PORTS'(1) << lock_owner_q;
  assign eligible       = (lock_state_q == LOCK_HELD) ? (port_request_valid & owner_mask)
                                                      : port_request_valid;
  assign pointer_frozen = (lock_state_q == LOCK_HELD);
  assign lock_counter_d = lock_counter_q + 1'b1;

  // Lock FSM: acquire on a locked grant; release on an unlocked owner access
  // or, with priority, when the held-cycle count reaches LOCK_MAX_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q   <= LOCK_IDLE;
      lock_owner_q   <= '0;
      lock_counter_q <= '0;
    end else begin
      case (lock_state_q)
        LOCK_IDLE: begin
          if (grant_valid && port_lock[grant_index]) begin
            lock_state_q   <= LOCK_HELD;
            lock_owner_q   <= grant_index;
            lock_counter_q <= '0;
          end
        end
        LOCK_HELD: begin
          if (lock_counter_d == CNT_W'(LOCK_MAX_CYCLES)) begin
            lock_state_q   <= LOCK_IDLE;
            lock_counter_q <= '0;
          end else if (grant_valid && !port_lock[grant_index]) begin
            lock_state_q   <= LOCK_IDLE;
            lock_counter_q <= '0;
          end else begin
            lock_counter_q <= lock_counter_d;
          end
        end
        default: lock_state_q <= LOCK_IDLE;
      endcase
    end
  end
`else
  assign eligible       = port_request_valid;
  assign pointer_frozen = 1'b0;
`endif

  round_robin_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .request     (eligible),
    .pointer     (priority_pointer_q),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  assign port_grant = grant;

  // Next pointer: one past the winner (wrapping), held when idle or locked.
  always_comb begin
    priority_pointer_d = priority_pointer_q;
    if (grant_valid && !pointer_frozen) begin
      priority_pointer_d = (grant_index == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

  // Route the granted port's payload to the memory; everything 0 when idle.
  always_comb begin
    data_memory_enable       = grant_valid;
    data_memory_address      = '0;
    data_memory_write_data   = '0;
    data_memory_byte_enable  = '0;
    data_memory_write_enable = 1'b0;
    if (grant_valid) begin
      data_memory_address      = port_address[DMEM_ADDR_WIDTH*int'(grant_index) +: DMEM_ADDR_WIDTH];
      data_memory_write_data   = port_write_data[DMEM_DATA_WIDTH*int'(grant_index) +: DMEM_DATA_WIDTH];
      data_memory_write_enable = port_write_enable[grant_index];
      if (port_write_enable[grant_index]) begin
        data_memory_byte_enable = port_byte_enable[DMEM_BE_WIDTH*int'(grant_index) +: DMEM_BE_WIDTH];
      end
    end
  end

  // Pointer and response tracking; a grant in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      priority_pointer_q  <= '0;
      response_port_q     <= '0;
      response_is_store_q <= 1'b0;
    end else begin
      priority_pointer_q  <= priority_pointer_d;
      response_port_q     <= grant;
      response_is_store_q <= grant_valid & port_write_enable[grant_index];
    end
  end

  // Stores are acknowledged with zero data; loads see the memory's read port.
  assign port_response_valid = response_port_q;
  assign port_read_data      = (|response_port_q && !response_is_store_q) ? data_memory_read_data : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: a 2-port instance driven from
// vector tables with a response scoreboard, and a 4-port instance for pointer
// wrap and full rotation. Lock rows run when DMEM_ARB_LOCK_EN is defined.
module tb_data_memory_arbiter;

  localparam logic [31:0] WD0 = 32'h0000_C0DE;
  localparam logic [31:0] WD1 = 32'hABAB_ABAB;
  localparam logic [3:0]  BE0 = 4'b1111;
  localparam logic [3:0]  BE1 = 4'b0100;

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  exp_grant;
  } vec_t;

  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req2, we2, lock2, grant2, rv2;
  logic [63:0] addr2, wdata2;
  logic [7:0]  be2;
  logic [31:0] rd2, maddr2, mwd2, mrd2;
  logic [3:0]  mbe2;
  logic        men2, mwe2;

  logic [3:0]   req4, we4, lock4, grant4, rv4;
  logic [127:0] addr4, wdata4;
  logic [15:0]  be4;
  logic [31:0]  rd4, maddr4, mwd4, mrd4;
  logic [3:0]   mbe4;
  logic         men4, mwe4;

  int n_checks = 0;
  int n_errors = 0;
  rsp_t sb[$];
  vec_t tbl[13];
  vec_t ltbl[14];

  data_memory_arbiter #(.NUM_PORTS(2), .LOCK_MAX_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .port_request_valid(req2), .port_address(addr2), .port_write_data(wdata2),
    .port_byte_enable(be2), .port_write_enable(we2),
`ifdef DMEM_ARB_LOCK_EN
    .port_lock(lock2),
`endif
    .port_grant(grant2), .port_response_valid(rv2), .port_read_data(rd2),
    .data_memory_enable(men2), .data_memory_address(maddr2),
    .data_memory_write_data(mwd2), .data_memory_byte_enable(mbe2),
    .data_memory_write_enable(mwe2), .data_memory_read_data(mrd2)
  );

  data_memory_arbiter #(.NUM_PORTS(4)) dut4 (
    .clk(clk), .rst(rst),
    .port_request_valid(req4), .port_address(addr4), .port_write_data(wdata4),
    .port_byte_enable(be4), .port_write_enable(we4),
`ifdef DMEM_ARB_LOCK_EN
    .port_lock(lock4),
`endif
    .port_grant(grant4), .port_response_valid(rv4), .port_read_data(rd4),
    .data_memory_enable(men4), .data_memory_address(maddr4),
    .data_memory_write_data(mwd4), .data_memory_byte_enable(mbe4),
    .data_memory_write_enable(mwe4), .data_memory_read_data(mrd4)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous-read memory models: data appears the cycle after a read.
  always @(posedge clk) mrd2 <= (men2 && !mwe2) ? rd_model(maddr2) : 32'hBAD0_0BAD;
  always @(posedge clk) mrd4 <= (men4 && !mwe4) ? rd_model(maddr4) : 32'hBAD0_0BAD;

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] g);
    vec_t v;
    v.req = req; v.we = we; v.lock = lock; v.a0 = a0; v.a1 = a1; v.exp_grant = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req2 = '0; we2 = '0; lock2 = '0;
    req4 = '0; we4 = '0; lock4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    rsp_t e;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    @(negedge clk);
    req2 = v.req; we2 = v.we; lock2 = v.lock;
    addr2 = {v.a1, v.a0};
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rv2), 32'(e.valid));
      if (e.valid != 2'b00) chk({tag, "_rsp_data"}, rd2, e.data);
    end
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
    e.valid = v.exp_grant; e.data = '0;
    if (v.exp_grant == 2'b01) begin
      e_en = 1'b1; e_addr = v.a0; e_wd = WD0; e_we = v.we[0]; e_be = v.we[0] ? BE0 : 4'b0000;
      e.data = v.we[0] ? 32'h0 : rd_model(v.a0);
    end else if (v.exp_grant == 2'b10) begin
      e_en = 1'b1; e_addr = v.a1; e_wd = WD1; e_we = v.we[1]; e_be = v.we[1] ? BE1 : 4'b0000;
      e.data = v.we[1] ? 32'h0 : rd_model(v.a1);
    end
    chk({tag, "_grant"}, 32'(grant2), 32'(v.exp_grant));
    chk({tag, "_mem_en"}, 32'(men2), 32'(e_en));
    chk({tag, "_mem_addr"}, maddr2, e_addr);
    chk({tag, "_mem_be"}, 32'(mbe2), 32'(e_be));
    chk({tag, "_mem_we"}, 32'(mwe2), 32'(e_we));
    if (e_en) chk({tag, "_mem_wdata"}, mwd2, e_wd);
    sb.push_back(e);
  endtask

  logic [3:0] seq4_req [8];
  logic [3:0] seq4_grant [8];

  initial begin
    rst = 1'b1;
    req2 = '0; we2 = '0; lock2 = '0; addr2 = '0; wdata2 = {WD1, WD0}; be2 = {BE1, BE0};
    req4 = '0; we4 = '0; lock4 = '0; wdata4 = '0; be4 = '0;
    addr4 = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};

    tbl[0]  = mk(2'b11, 2'b00, 2'b00, 32'h10,  32'h20,  2'b01);
    tbl[1]  = mk(2'b11, 2'b00, 2'b00, 32'h10,  32'h20,  2'b10);
    tbl[2]  = mk(2'b11, 2'b00, 2'b00, 32'h14,  32'h24,  2'b01);
    tbl[3]  = mk(2'b11, 2'b00, 2'b00, 32'h18,  32'h24,  2'b10);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00, 32'h100, 32'h0,   2'b01);
    tbl[5]  = mk(2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00);
    tbl[6]  = mk(2'b10, 2'b10, 2'b00, 32'h0,   32'h202, 2'b10);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00);
    tbl[8]  = mk(2'b01, 2'b01, 2'b00, 32'h40,  32'h0,   2'b01);
    tbl[9]  = mk(2'b01, 2'b00, 2'b00, 32'h44,  32'h0,   2'b01);
    tbl[10] = mk(2'b10, 2'b00, 2'b00, 32'h0,   32'h300, 2'b10);
    tbl[11] = mk(2'b11, 2'b11, 2'b00, 32'h50,  32'h60,  2'b01);
    tbl[12] = mk(2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00);

    ltbl[0]  = mk(2'b11, 2'b00, 2'b01, 32'h80, 32'h90, 2'b01);
    ltbl[1]  = mk(2'b11, 2'b00, 2'b01, 32'h84, 32'h90, 2'b01);
    ltbl[2]  = mk(2'b10, 2'b00, 2'b00, 32'h0,  32'h90, 2'b00);
    ltbl[3]  = mk(2'b11, 2'b00, 2'b00, 32'h88, 32'h90, 2'b01);
    ltbl[4]  = mk(2'b11, 2'b00, 2'b00, 32'h8C, 32'h90, 2'b10);
    ltbl[5]  = mk(2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  2'b00);
    ltbl[6]  = mk(2'b11, 2'b00, 2'b01, 32'hA0, 32'hB0, 2'b01);
    ltbl[7]  = mk(2'b11, 2'b00, 2'b01, 32'hA4, 32'hB0, 2'b01);
    ltbl[8]  = mk(2'b11, 2'b00, 2'b01, 32'hA8, 32'hB0, 2'b01);
    ltbl[9]  = mk(2'b11, 2'b00, 2'b01, 32'hAC, 32'hB0, 2'b01);
    ltbl[10] = mk(2'b11, 2'b00, 2'b01, 32'hC0, 32'hB0, 2'b01);
    ltbl[11] = mk(2'b11, 2'b00, 2'b01, 32'hC4, 32'hB0, 2'b10);
    ltbl[12] = mk(2'b01, 2'b00, 2'b00, 32'hC8, 32'h0,  2'b01);
    ltbl[13] = mk(2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  2'b00);

    // 4-port: pointer driven to 3, wrap to 0, then full rotation
    seq4_req[0] = 4'b0100; seq4_grant[0] = 4'b0100;
    seq4_req[1] = 4'b1001; seq4_grant[1] = 4'b1000;
    seq4_req[2] = 4'b1001; seq4_grant[2] = 4'b0001;
    seq4_req[3] = 4'b1111; seq4_grant[3] = 4'b0010;
    seq4_req[4] = 4'b1111; seq4_grant[4] = 4'b0100;
    seq4_req[5] = 4'b1111; seq4_grant[5] = 4'b1000;
    seq4_req[6] = 4'b1111; seq4_grant[6] = 4'b0001;
    seq4_req[7] = 4'b0000; seq4_grant[7] = 4'b0000;

    do_reset();
    #1;
    chk("reset_rsp_valid", 32'(rv2), 32'h0);
    chk("reset_read_data", rd2, 32'h0);
    chk("reset_grant", 32'(grant2), 32'h0);
    chk("reset_mem_en", 32'(men2), 32'h0);
    chk("reset_rsp_valid4", 32'(rv4), 32'h0);

    for (int i = 0; i < 13; i++) apply_row(tbl[i], $sformatf("row%0d", i));

    // Reset in the cycle after a grant, and a grant made during reset
    sb.delete();
    @(negedge clk); req2 = 2'b01; we2 = 2'b00; addr2 = {32'h0, 32'h0000_0240};
    #1; chk("rstseq_grant_a", 32'(grant2), 32'h1);
    @(negedge clk); rst = 1'b1; req2 = 2'b00;
    #1; chk("rstseq_rsp_b", 32'(rv2), 32'h1);
    chk("rstseq_data_b", rd2, rd_model(32'h0000_0240));
    @(negedge clk); rst = 1'b0; req2 = 2'b11; addr2 = {32'h0000_0344, 32'h0000_0340};
    #1; chk("rstseq_rsp_c", 32'(rv2), 32'h0);
    chk("rstseq_ptr_c", 32'(grant2), 32'h1);
    @(negedge clk); rst = 1'b1; req2 = 2'b10;
    #1; chk("rstseq_rsp_d", 32'(rv2), 32'h1);
    chk("rstseq_grant_d", 32'(grant2), 32'h2);
    @(negedge clk); rst = 1'b0; req2 = 2'b11;
    #1; chk("rstseq_rsp_e", 32'(rv2), 32'h0);
    chk("rstseq_grant_e", 32'(grant2), 32'h1);
    @(negedge clk); req2 = 2'b00;
    #1; chk("rstseq_rsp_f", 32'(rv2), 32'h1);
    chk("rstseq_data_f", rd2, rd_model(32'h0000_0340));

    for (int i = 0; i < 8; i++) begin
      logic [31:0] e_addr;
      @(negedge clk); req4 = seq4_req[i];
      #1;
      chk($sformatf("p4_step%0d_grant", i), 32'(grant4), 32'(seq4_grant[i]));
      e_addr = '0;
      for (int p = 0; p < 4; p++) if (seq4_grant[i][p]) e_addr = 32'h1000 + 32'(4 * p);
      chk($sformatf("p4_step%0d_addr", i), maddr4, e_addr);
      if (i > 0) chk($sformatf("p4_step%0d_rsp", i), 32'(rv4), 32'(seq4_grant[i-1]));
    end

`ifdef DMEM_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < 14; i++) apply_row(ltbl[i], $sformatf("lock%0d", i));
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-ported data memory between `NUM_PORTS` core-side load/store requesters in the multicore build. It sits between each core's load-store unit outputs (aligned write data, byte enables, write enable) and the shared DMEM macro, which has a one-cycle synchronous read. It grants one requester per cycle with round-robin fairness and routes the read data or write acknowledge back to the granted port one cycle later. An optional lock mode keeps ownership with one port for read-modify-write sequences.

## Interface
- `NUM_PORTS`, 2: number of requesters, 2..8.
- `LOCK_MAX_CYCLES`, 16: forced lock-release bound in cycles. Used only with the lock feature.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `port_request_valid`  in  NUM_PORTS  per-port access request.
- `port_address`  in  NUM_PORTS*32  byte address; port i occupies bits [32i+31:32i].
- `port_write_data`  in  NUM_PORTS*32  aligned store data.
- `port_byte_enable`  in  NUM_PORTS*4  store byte enables.
- `port_write_enable`  in  NUM_PORTS  1 = store, 0 = load.
- `port_lock`  in  NUM_PORTS  lock request. Present only with `DMEM_ARB_LOCK_EN`.
- `port_grant`  out  NUM_PORTS  one-hot; the request is accepted in this cycle.
- `port_response_valid`  out  NUM_PORTS  one-hot; the access granted in the previous cycle has completed.
- `port_read_data`  out  32  read data, shared by all ports; qualify with `port_response_valid`.
- `data_memory_enable`  out  1  DMEM access this cycle.
- `data_memory_address`  out  32
- `data_memory_write_data`  out  32
- `data_memory_byte_enable`  out  4  forced to 0 for loads.
- `data_memory_write_enable`  out  1
- `data_memory_read_data`  in  32  valid in the cycle after a read is issued.

## Operation
- Handshake:
  - A port holds `port_request_valid` and its payload stable until it sees `port_grant`.
  - The transfer occurs in the cycle where valid and grant are both high.
  - Grant never asserts without valid.
- Arbitration:
  - Grant is combinational from `port_request_valid` and the registered `priority_pointer`.
  - The winner is the first requesting port at or after the pointer, searching in increasing index with wrap-around.
- Pointer update:
  - After any grant, `priority_pointer` becomes the granted index + 1 (mod NUM_PORTS).
  - With no grant, the pointer is unchanged.
- Memory drive:
  - The granted port's payload is muxed onto the `data_memory_*` outputs in the same cycle.
  - `data_memory_enable` equals (any grant).
  - With no grant, all memory outputs are 0.
- Response:
  - A registered `response_port` (one-hot) is loaded with the grant vector.
  - Next cycle, `port_response_valid = response_port`.
  - `port_read_data = data_memory_read_data` for loads and 0 for stores.
  - Stores also receive `port_response_valid` as a write acknowledge.
- Throughput: one access per cycle, back-to-back. A port may re-request in the cycle its response arrives.
- Reset:
  - `priority_pointer=0`, `response_port=0`, lock state cleared.
  - All outputs are 0 in the cycle after reset, except the combinational grant and memory outputs, which follow the inputs.
  - An access granted in the cycle reset is asserted gets no response.

## Timing
- Grant latency: 0 cycles from request when the port wins.
- Response latency: exactly 1 cycle after the grant.
- Worst-case wait with all ports requesting continuously: NUM_PORTS−1 cycles.
- Simultaneous requests: exactly one grant per cycle.
- Pointer wrap: when port NUM_PORTS−1 is granted, the pointer becomes 0.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - `port_lock` exists.
  - A grant to port i with `port_lock[i]=1` sets `lock_active` and `lock_owner=i`.
  - While locked, only `lock_owner` can be granted, and the pointer is frozen.
  - The lock releases after the owner's granted access with `port_lock=0`, or when `lock_counter` reaches `LOCK_MAX_CYCLES` (forced release on that edge).
  - `lock_counter` resets to 0 on lock acquisition and increments each locked cycle.
- `DMEM_ARB_LOCK_EN` undefined: there is no lock port and no lock state, and behaviour is pure round-robin.

## Structure
- Shared package `dmem_arbiter_pkg`:
  - `DMEM_ADDR_WIDTH=32`, `DMEM_DATA_WIDTH=32`, `DMEM_BE_WIDTH=4`
  - the `lock_state_t` enum {`LOCK_IDLE`, `LOCK_HELD`}
- One sub-module, `round_robin_picker`: a combinational request vector + pointer to one-hot grant + encoded index. It is reusable by the future instruction-memory arbiter.

## Test plan
- NUM_PORTS=2:
  - Port0 reads 0x100 alone → grant[0] in cycle 0, `data_memory_address=0x100`, `byte_enable=0`.
  - Memory returns 0xDEADBEEF → `port_response_valid=2'b01` with read data 0xDEADBEEF in cycle 1.
- Both ports request continuously from reset → grants alternate 01,10,01,10. Each response arrives one cycle after its grant.
- Port1 stores 0xAB, byte enable 4'b0100, address 0x202 → memory sees write_enable=1, byte_enable=0100, data 0xABABABAB. Next cycle `port_response_valid=2'b10` and read data is 0.
- NUM_PORTS=4, pointer=3, requests 4'b1001 → port3 granted, then pointer=0 and port0 granted next.
- `rst` asserted in the cycle after a grant → `port_response_valid` is 0 next cycle and the pointer is 0.
- With `DMEM_ARB_LOCK_EN`, LOCK_MAX_CYCLES=4:
  - Port0 locks while port1 requests → port1 is blocked until port0 issues an access with lock=0.
  - Holding lock=1 indefinitely → forced release after 4 locked cycles, after which port1 is granted.
